game_timer_ctrl: RTL and testbench

GAME_TIMER_CTRL -- requirements
Module: game_timer_ctrl

---
 rtl/game_timer_pkg.sv | 53 +++++
 rtl/bcd_mod_counter.sv | 61 ++++++
 rtl/game_timer_ctrl.sv | 151 +++++++++++++++
 tb/tb_game_timer_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/game_timer_pkg.sv
// Shared types, BCD limits and preset conversion for the MM:SS countdown timer.
// Latency: n/a (types and elaboration-time helpers only).
// Backpressure: n/a.
package game_timer_pkg;

  // Controller state encoding, visible on the 2-bit state output
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // BCD digit limits
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;
  localparam logic [3:0] DIGIT_MAX    = 4'd9;
  localparam int         MIN_MAX      = 99;

  // Largest representable time, 99:59, expressed in seconds
  localparam int PRESET_MAX = (MIN_MAX + 1) * 60 - 1;

  // Packed MM:SS time, one nibble per BCD digit
  typedef struct packed {
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
  } bcd_time_t;

  // Convert a seconds count to MM:SS BCD; out-of-range inputs are clamped
  // so that a bad parameter cannot produce illegal digits.
  function automatic bcd_time_t preset_to_bcd(input int secs);
    int        clamped;
    int        mins;
    int        rem_s;
    bcd_time_t r;
    if (secs < 0) begin
      clamped = 0;
    end else if (secs > PRESET_MAX) begin
      clamped = PRESET_MAX;
    end else begin
      clamped = secs;
    end
    mins       = clamped / 60;
    rem_s      = clamped % 60;
    r.min_tens = 4'(mins / 10);
    r.min_ones = 4'(mins % 10);
    r.sec_tens = 4'(rem_s / 10);
    r.sec_ones = 4'(rem_s % 10);
    return r;
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter, modulus 60 or 100, with load / decrement / increment.
// Latency: value updates on the edge after the control strobe; carry/borrow are combinational.
// Backpressure: none; strobes are plain enables, priority load > dec > inc.
module bcd_mod_counter
  import game_timer_pkg::*;
#(
  parameter int         MODULUS   = 60,
  parameter logic [7:0] RESET_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       inc,
  input  logic       dec,
  output logic [7:0] value,
  output logic       carry,
  output logic       borrow
);

  // Tens digit ceiling: 5 for a seconds field, 9 for a minutes field
  localparam logic [3:0] TENS_MAX = (MODULUS == 60) ? SEC_TENS_MAX : DIGIT_MAX;

  logic [3:0] tens;
  logic [3:0] ones;
  logic       at_max;
  logic       at_zero;

  assign tens    = value[7:4];
  assign ones    = value[3:0];
  assign at_max  = (tens == TENS_MAX) && (ones == DIGIT_MAX);
  assign at_zero = (tens == 4'd0) && (ones == 4'd0);

  // Wrap indications only fire when that operation actually wins this cycle
  assign carry  = inc && !dec && !load && at_max;
  assign borrow = dec && !load && at_zero;

  // Digit register: reset / load / BCD decrement with borrow / BCD increment with wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      value <= RESET_VAL;
    end else if (load) begin
      value <= load_val;
    end else if (dec) begin
      if (ones == 4'd0) begin
        value[3:0] <= DIGIT_MAX;
        value[7:4] <= (tens == 4'd0) ? TENS_MAX : tens - 4'd1;
      end else begin
        value[3:0] <= ones - 4'd1;
      end
    end else if (inc) begin
      if (ones == DIGIT_MAX) begin
        value[3:0] <= 4'd0;
        value[7:4] <= (tens == TENS_MAX) ? 4'd0 : tens + 4'd1;
      end else begin
        value[3:0] <= ones + 4'd1;
      end
    end
  end

endmodule

// File: rtl/game_timer_ctrl.sv
// MM:SS countdown game timer: set, run, pause, alarm; BCD display outputs.
// Latency: every output reflects the causing input one clk edge later.
// Backpressure: none; tick and buttons are single-cycle enables, clear is a level.
module game_timer_ctrl
  import game_timer_pkg::*;
#(
  parameter int PRESET_SEC = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       start_btn,
  input  logic       clear,
  input  logic       inc_min,
  input  logic       inc_sec,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic [1:0] state,
  output logic       alarm,
  output logic       done_pulse
);

  localparam bcd_time_t  PRESET_BCD = preset_to_bcd(PRESET_SEC);
  localparam logic [7:0] PRESET_SS  = {PRESET_BCD.sec_tens, PRESET_BCD.sec_ones};
  localparam logic [7:0] PRESET_MM  = {PRESET_BCD.min_tens, PRESET_BCD.min_ones};

  state_t     state_q;
  logic [7:0] sec_val;
  logic [7:0] min_val;
  logic       time_zero;
  logic       time_one;

  logic       reload;
  logic       sec_inc;
  logic       sec_dec;
  logic       min_inc;
  logic       min_dec;
  logic       sec_carry;
  logic       sec_borrow;
  logic       min_carry;
  logic       min_borrow;
  logic       unused_flags;

  assign time_zero = (sec_val == 8'h00) && (min_val == 8'h00);
  assign time_one  = (sec_val == 8'h01) && (min_val == 8'h00);

  // Minutes step down only when the seconds field wraps 00 -> 59
  assign min_dec = sec_borrow;

  // Seconds never carry into minutes, and minutes never borrow below 00
  // because RUN always leaves for DONE at 00:01.
  assign unused_flags = ^{sec_carry, min_carry, min_borrow};

  // Counter strobes, decoded with the same priority as the state register
  always_comb begin
    reload  = 1'b0;
    sec_inc = 1'b0;
    sec_dec = 1'b0;
    min_inc = 1'b0;
    if (clear) begin
      reload = 1'b1;
    end else if (start_btn) begin
      reload = (state_q == ST_DONE);
    end else if (state_q == ST_RUN) begin
      sec_dec = tick && !time_zero;
    end else if (state_q == ST_IDLE) begin
      sec_inc = inc_sec;
      min_inc = inc_min;
    end
  end

  bcd_mod_counter #(
    .MODULUS   (60),
    .RESET_VAL (PRESET_SS)
  ) u_sec (
    .clk      (clk),
    .rst      (rst),
    .load     (reload),
    .load_val (PRESET_SS),
    .inc      (sec_inc),
    .dec      (sec_dec),
    .value    (sec_val),
    .carry    (sec_carry),
    .borrow   (sec_borrow)
  );

  bcd_mod_counter #(
    .MODULUS   (100),
    .RESET_VAL (PRESET_MM)
  ) u_min (
    .clk      (clk),
    .rst      (rst),
    .load     (reload),
    .load_val (PRESET_MM),
    .inc      (min_inc),
    .dec      (min_dec),
    .value    (min_val),
    .carry    (min_carry),
    .borrow   (min_borrow)
  );

  // Controller FSM with registered alarm and done_pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      alarm      <= 1'b0;
      done_pulse <= 1'b0;
    end else begin
      done_pulse <= 1'b0;
      if (clear) begin
        state_q <= ST_IDLE;
        alarm   <= 1'b0;
      end else if (start_btn) begin
        case (state_q)
          ST_IDLE: begin
            if (!time_zero) begin
              state_q <= ST_RUN;
            end
          end
          ST_RUN: begin
            state_q <= ST_PAUSE;
          end
          ST_PAUSE: begin
            state_q <= ST_RUN;
          end
          ST_DONE: begin
            state_q <= ST_IDLE;
            alarm   <= 1'b0;
          end
          default: begin
            state_q <= ST_IDLE;
            alarm   <= 1'b0;
          end
        endcase
      end else if ((state_q == ST_RUN) && tick && time_one) begin
        state_q    <= ST_DONE;
        alarm      <= 1'b1;
        done_pulse <= 1'b1;
      end
    end
  end

  assign state    = state_q;
  assign sec_ones = sec_val[3:0];
  assign sec_tens = sec_val[7:4];
  assign min_ones = min_val[3:0];
  assign min_tens = min_val[7:4];

endmodule

// File: tb/tb_game_timer_ctrl.sv
// Bench for game_timer_ctrl: three instances (presets 60, 3, 0) share stimulus.
// Directed scenarios check constants; a random run checks against a seconds-level model.
// All inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_game_timer_ctrl;

  localparam int NDUT = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tick = 1'b0;
  logic start_btn = 1'b0;
  logic clear = 1'b0;
  logic inc_min = 1'b0;
  logic inc_sec = 1'b0;

  logic [3:0] w_so[NDUT];
  logic [3:0] w_st[NDUT];
  logic [3:0] w_mo[NDUT];
  logic [3:0] w_mt[NDUT];
  logic [1:0] w_state[NDUT];
  logic       w_alarm[NDUT];
  logic       w_dp[NDUT];

  int errors = 0;
  int checks = 0;

  // Reference model: minutes and seconds as plain integers, state by its encoding
  int m_min[NDUT];
  int m_sec[NDUT];
  int m_st[NDUT];
  bit m_dp[NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    game_timer_ctrl #(
      .PRESET_SEC((g == 0) ? 60 : ((g == 1) ? 3 : 0))
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .tick       (tick),
      .start_btn  (start_btn),
      .clear      (clear),
      .inc_min    (inc_min),
      .inc_sec    (inc_sec),
      .sec_ones   (w_so[g]),
      .sec_tens   (w_st[g]),
      .min_ones   (w_mo[g]),
      .min_tens   (w_mt[g]),
      .state      (w_state[g]),
      .alarm      (w_alarm[g]),
      .done_pulse (w_dp[g])
    );
  end

  always #5 clk = ~clk;

  function automatic int preset_of(int i);
    return (i == 0) ? 60 : ((i == 1) ? 3 : 0);
  endfunction

  function automatic logic [15:0] obs_time(int i);
    return {w_mt[i], w_mo[i], w_st[i], w_so[i]};
  endfunction

  function automatic logic [15:0] bcd_of(int m, int s);
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic model_update(int i, bit r, bit c, bit s, bit t, bit im, bit is);
    int prev;
    int total;
    prev  = m_st[i];
    total = m_min[i] * 60 + m_sec[i];
    if (r || c) begin
      m_st[i] = 0;
      total   = preset_of(i);
    end else if (s) begin
      if (prev == 0) m_st[i] = (total != 0) ? 1 : 0;
      else if (prev == 1) m_st[i] = 2;
      else if (prev == 2) m_st[i] = 1;
      else begin
        m_st[i] = 0;
        total   = preset_of(i);
      end
    end else if (prev == 1 && t && total > 0) begin
      total = total - 1;
      if (total == 0) m_st[i] = 3;
    end else if (prev == 0) begin
      if (im) total = ((total / 60 + 1) % 100) * 60 + total % 60;
      if (is) total = (total / 60) * 60 + (total % 60 + 1) % 60;
    end
    m_min[i] = total / 60;
    m_sec[i] = total % 60;
    m_dp[i]  = !r && (m_st[i] == 3) && (prev != 3);
  endtask

  task automatic step(input bit r, input bit c, input bit s, input bit t, input bit im, input bit is);
    rst = r; clear = c; start_btn = s; tick = t; inc_min = im; inc_sec = is;
    @(posedge clk);
    for (int i = 0; i < NDUT; i++) model_update(i, r, c, s, t, im, is);
    #1;
    rst = 1'b0; clear = 1'b0; start_btn = 1'b0; tick = 1'b0; inc_min = 1'b0; inc_sec = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] exp_pre[NDUT];
    exp_pre = '{16'h0100, 16'h0003, 16'h0000};
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < NDUT; i++) begin
      checks++; if (w_state[i] !== 2'd0) begin errors++; $display("FAIL reset_state[%0d]: got %0d expected 0", i, w_state[i]); end
      checks++; if (obs_time(i) !== exp_pre[i]) begin errors++; $display("FAIL reset_time[%0d]: got %h expected %h", i, obs_time(i), exp_pre[i]); end
      checks++; if (w_alarm[i] !== 1'b0) begin errors++; $display("FAIL reset_alarm[%0d]: got %b expected 0", i, w_alarm[i]); end
      checks++; if (w_dp[i] !== 1'b0) begin errors++; $display("FAIL reset_done_pulse[%0d]: got %b expected 0", i, w_dp[i]); end
    end
  endtask

  task automatic test_countdown();
    logic [15:0] exp_t[3];
    exp_t = '{16'h0002, 16'h0001, 16'h0000};
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    checks++; if (w_state[1] !== 2'd1 || obs_time(1) !== 16'h0003) begin errors++; $display("FAIL cd_start: got st=%0d t=%h expected st=1 t=0003", w_state[1], obs_time(1)); end
    checks++; if (w_state[2] !== 2'd0 || obs_time(2) !== 16'h0000) begin errors++; $display("FAIL zero_preset_start: got st=%0d t=%h expected st=0 t=0000", w_state[2], obs_time(2)); end
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 1, 0, 0);
      checks++; if (obs_time(1) !== exp_t[k]) begin errors++; $display("FAIL cd_tick%0d_time: got %h expected %h", k, obs_time(1), exp_t[k]); end
      checks++; if (w_dp[1] !== (k == 2)) begin errors++; $display("FAIL cd_tick%0d_done_pulse: got %b expected %b", k, w_dp[1], k == 2); end
    end
    checks++; if (w_state[1] !== 2'd3 || w_alarm[1] !== 1'b1) begin errors++; $display("FAIL cd_done: got st=%0d alarm=%b expected st=3 alarm=1", w_state[1], w_alarm[1]); end
    step(0, 0, 0, 0, 0, 0);
    checks++; if (w_dp[1] !== 1'b0 || w_state[1] !== 2'd3 || w_alarm[1] !== 1'b1) begin errors++; $display("FAIL cd_after_done: got dp=%b st=%0d alarm=%b expected dp=0 st=3 alarm=1", w_dp[1], w_state[1], w_alarm[1]); end
    step(0, 0, 0, 1, 0, 0);
    checks++; if (obs_time(1) !== 16'h0000 || w_dp[1] !== 1'b0) begin errors++; $display("FAIL cd_done_tick: got t=%h dp=%b expected t=0000 dp=0", obs_time(1), w_dp[1]); end
    step(0, 0, 1, 0, 0, 0);
    checks++; if (w_state[1] !== 2'd0 || obs_time(1) !== 16'h0003 || w_alarm[1] !== 1'b0) begin errors++; $display("FAIL cd_ack: got st=%0d t=%h alarm=%b expected st=0 t=0003 alarm=0", w_state[1], obs_time(1), w_alarm[1]); end
  endtask

  task automatic test_pause();
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    checks++; if (w_state[0] !== 2'd1 || obs_time(0) !== 16'h0100) begin errors++; $display("FAIL pause_start: got st=%0d t=%h expected st=1 t=0100", w_state[0], obs_time(0)); end
    step(0, 0, 0, 1, 0, 0);
    checks++; if (obs_time(0) !== 16'h0059) begin errors++; $display("FAIL pause_borrow: got %h expected 0059", obs_time(0)); end
    step(0, 0, 1, 1, 0, 0);
    checks++; if (w_state[0] !== 2'd2 || obs_time(0) !== 16'h0059) begin errors++; $display("FAIL pause_enter: got st=%0d t=%h expected st=2 t=0059", w_state[0], obs_time(0)); end
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 0, 1, 0, 0);
      checks++; if (w_state[0] !== 2'd2 || obs_time(0) !== 16'h0059) begin errors++; $display("FAIL pause_hold%0d: got st=%0d t=%h expected st=2 t=0059", k, w_state[0], obs_time(0)); end
    end
    step(0, 0, 1, 0, 0, 0);
    checks++; if (w_state[0] !== 2'd1 || obs_time(0) !== 16'h0059) begin errors++; $display("FAIL pause_resume: got st=%0d t=%h expected st=1 t=0059", w_state[0], obs_time(0)); end
    step(0, 0, 0, 1, 0, 0);
    checks++; if (obs_time(0) !== 16'h0058) begin errors++; $display("FAIL pause_resume_tick: got %h expected 0058", obs_time(0)); end
  endtask

  task automatic test_wrap();
    step(1, 0, 0, 0, 0, 0);
    repeat (98) step(0, 0, 0, 0, 1, 0);
    repeat (59) step(0, 0, 0, 0, 0, 1);
    checks++; if (obs_time(0) !== 16'h9959) begin errors++; $display("FAIL wrap_setup: got %h expected 9959", obs_time(0)); end
    step(0, 0, 0, 0, 1, 0);
    checks++; if (obs_time(0) !== 16'h0059) begin errors++; $display("FAIL wrap_min: got %h expected 0059", obs_time(0)); end
    step(0, 0, 0, 0, 0, 1);
    checks++; if (obs_time(0) !== 16'h0000) begin errors++; $display("FAIL wrap_sec: got %h expected 0000", obs_time(0)); end
    step(0, 0, 1, 0, 0, 0);
    checks++; if (w_state[0] !== 2'd0 || obs_time(0) !== 16'h0000) begin errors++; $display("FAIL wrap_start_zero: got st=%0d t=%h expected st=0 t=0000", w_state[0], obs_time(0)); end
    step(0, 0, 0, 0, 1, 1);
    checks++; if (obs_time(0) !== 16'h0101) begin errors++; $display("FAIL inc_both: got %h expected 0101", obs_time(0)); end
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1);
    checks++; if (w_state[0] !== 2'd1 || obs_time(0) !== 16'h0101) begin errors++; $display("FAIL inc_in_run: got st=%0d t=%h expected st=1 t=0101", w_state[0], obs_time(0)); end
  endtask

  task automatic test_clear();
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    repeat (50) step(0, 0, 0, 1, 0, 0);
    checks++; if (obs_time(0) !== 16'h0010 || w_state[0] !== 2'd1) begin errors++; $display("FAIL clear_setup: got st=%0d t=%h expected st=1 t=0010", w_state[0], obs_time(0)); end
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 0, 1, 0, 0);
      checks++; if (w_state[0] !== 2'd0 || obs_time(0) !== 16'h0100 || w_dp[0] !== 1'b0) begin errors++; $display("FAIL clear_held%0d: got st=%0d t=%h dp=%b expected st=0 t=0100 dp=0", k, w_state[0], obs_time(0), w_dp[0]); end
    end
    step(0, 0, 0, 1, 0, 0);
    checks++; if (w_state[0] !== 2'd0 || obs_time(0) !== 16'h0100) begin errors++; $display("FAIL clear_release: got st=%0d t=%h expected st=0 t=0100", w_state[0], obs_time(0)); end
  endtask

  task automatic test_rst_final();
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    checks++; if (obs_time(1) !== 16'h0001 || w_state[1] !== 2'd1) begin errors++; $display("FAIL rstfin_setup: got st=%0d t=%h expected st=1 t=0001", w_state[1], obs_time(1)); end
    step(1, 0, 0, 1, 0, 0);
    checks++; if (w_state[1] !== 2'd0 || obs_time(1) !== 16'h0003 || w_dp[1] !== 1'b0 || w_alarm[1] !== 1'b0) begin errors++; $display("FAIL rstfin: got st=%0d t=%h dp=%b alarm=%b expected st=0 t=0003 dp=0 alarm=0", w_state[1], obs_time(1), w_dp[1], w_alarm[1]); end
    step(0, 0, 0, 0, 0, 0);
    checks++; if (w_dp[1] !== 1'b0) begin errors++; $display("FAIL rstfin_after: got dp=%b expected 0", w_dp[1]); end
  endtask

  task automatic test_random();
    bit r, c, s, t, im, is;
    step(1, 0, 0, 0, 0, 0);
    for (int n = 0; n < 3000; n++) begin
      r  = ($urandom_range(0, 299) == 0);
      c  = ($urandom_range(0, 49) == 0);
      s  = ($urandom_range(0, 9) == 0);
      t  = ($urandom_range(0, 1) == 0);
      im = ($urandom_range(0, 5) == 0);
      is = ($urandom_range(0, 5) == 0);
      step(r, c, s, t, im, is);
      for (int i = 0; i < NDUT; i++) begin
        checks++; if (obs_time(i) !== bcd_of(m_min[i], m_sec[i])) begin errors++; $display("FAIL rnd_time[%0d] cyc %0d: got %h expected %h", i, n, obs_time(i), bcd_of(m_min[i], m_sec[i])); end
        checks++; if (w_state[i] !== 2'(m_st[i])) begin errors++; $display("FAIL rnd_state[%0d] cyc %0d: got %0d expected %0d", i, n, w_state[i], m_st[i]); end
        checks++; if (w_alarm[i] !== (m_st[i] == 3)) begin errors++; $display("FAIL rnd_alarm[%0d] cyc %0d: got %b expected %b", i, n, w_alarm[i], m_st[i] == 3); end
        checks++; if (w_dp[i] !== m_dp[i]) begin errors++; $display("FAIL rnd_done_pulse[%0d] cyc %0d: got %b expected %b", i, n, w_dp[i], m_dp[i]); end
        checks++; if (w_so[i] > 4'd9 || w_mo[i] > 4'd9 || w_mt[i] > 4'd9 || w_st[i] > 4'd5) begin errors++; $display("FAIL rnd_digits[%0d] cyc %0d: got %h expected legal BCD", i, n, obs_time(i)); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_pause();
    test_wrap();
    test_clear();
    test_rst_final();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
